// File: rtl/grid_mem_arbiter.sv
// ---------------------------------------------------------------------------
// grid_mem_arbiter
//
// Two-client arbiter for a single-port grid memory. A game controller (read,
// write and exclusive lock) and a display engine (read only) compete for the
// memory. Round-robin arbitration picks at most one access per cycle. Address,
// write data and write enable go to the memory as registered signals. Read
// data comes back one cycle after issue and is steered to its owner by a
// two-stage tag pipeline.
//
// Parameters
//   ADDR_MAX   last legal grid address; higher addresses are granted but
//              suppressed (no write, no read return) and flagged on addr_err
//   LOCK_MAX   maximum number of cycles the game may hold the lock
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   g_req/g_we/g_addr/    game request (held until g_gnt), write enable,
//   g_wdata/g_lock        address, write data, exclusive-lock request
//   d_req/d_addr          display read request (held until d_gnt), address
//   mem_rdata             memory read data (1-cycle synchronous read)
//   g_gnt, d_gnt          one-cycle accept pulses
//   g_rvalid, d_rvalid    read-data-valid pulses
//   rdata                 read data, mem_rdata passed through when valid
//   mem_addr/mem_wdata/   registered memory address, write data and write
//   mem_we                enable
//   addr_err              granted access had address > ADDR_MAX
//   lock_err              lock forcibly released on timeout
// ---------------------------------------------------------------------------
module grid_mem_arbiter #(
    parameter int unsigned ADDR_MAX = 251,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       g_req,
    input  logic       g_we,
    input  logic [7:0] g_addr,
    input  logic [7:0] g_wdata,
    input  logic       g_lock,
    input  logic       d_req,
    input  logic [7:0] d_addr,
    input  logic [7:0] mem_rdata,
    output logic       g_gnt,
    output logic       d_gnt,
    output logic       g_rvalid,
    output logic       d_rvalid,
    output logic [7:0] rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       addr_err,
    output logic       lock_err
);

    localparam logic [8:0] ADDR_MAX_C = 9'(ADDR_MAX);
    localparam logic [6:0] LOCK_MAX_C = 7'(LOCK_MAX);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_GAME = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

    // State registers
    lock_state_e state_q,      state_d;
    logic [6:0]  lock_cnt_q,   lock_cnt_d;
    logic        relock_blk_q, relock_blk_d;  // set by timeout, cleared when g_lock drops
    logic        favor_game_q, favor_game_d;  // round-robin pointer, 0 = display favored
    tag_t        tag1_q,       tag1_d;        // read issued this cycle
    tag_t        tag2_q;                      // read whose data is on mem_rdata now

    // Registered outputs
    logic        g_gnt_q,     g_gnt_d;
    logic        d_gnt_q,     d_gnt_d;
    logic [7:0]  mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic        addr_err_q,  addr_err_d;
    logic        lock_err_q,  lock_err_d;

    // Arbitration terms
    logic       locked;
    logic       timeout;
    logic       lock_release;
    logic       g_elig;
    logic       d_elig;
    logic       grant_g;
    logic       grant_d;
    logic       issue;
    logic [7:0] sel_addr;
    logic       addr_bad;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        relock_blk_d = relock_blk_q;
        favor_game_d = favor_game_q;
        lock_err_d   = 1'b0;

        locked       = (state_q == LOCKED);
        timeout      = locked && g_lock && (lock_cnt_q == LOCK_MAX_C);
        // A release (voluntary or forced) opens the memory to the display at
        // the same edge, so a waiting display read is not delayed a cycle.
        lock_release = locked && (!g_lock || timeout);

        // A requester whose grant is showing this cycle still has its req
        // high at this edge; masking it stops a second grant of that request.
        g_elig  = g_req && !g_gnt_q;
        d_elig  = d_req && !d_gnt_q && !(locked && !lock_release);

        // While locked the pointer always favors display (the lock was
        // entered on a game grant and only the game is granted since), so the
        // display wins the edge of a forced release.
        grant_g = g_elig && (!d_elig || favor_game_q);
        grant_d = d_elig && !grant_g;
        issue   = grant_g || grant_d;

        sel_addr = grant_g ? g_addr : d_addr;
        addr_bad = ({1'b0, sel_addr} > ADDR_MAX_C);

        g_gnt_d     = grant_g;
        d_gnt_d     = grant_d;
        mem_addr_d  = issue ? sel_addr : 8'h00;
        mem_we_d    = grant_g && g_we && !addr_bad;
        mem_wdata_d = mem_we_d ? g_wdata : 8'h00;
        addr_err_d  = issue && addr_bad;

        // Only legal reads travel down the tag pipeline.
        tag1_d.vld   = issue && !addr_bad && !(grant_g && g_we);
        tag1_d.owner = grant_g ? OWN_GAME : OWN_DISP;

        if (grant_g) begin
            favor_game_d = 1'b0;
        end else if (grant_d) begin
            favor_game_d = 1'b1;
        end

        if (!g_lock) begin
            relock_blk_d = 1'b0;
        end

        case (state_q)
            UNLOCKED: begin
                if (grant_g && g_lock && !relock_blk_q) begin
                    state_d    = LOCKED;
                    lock_cnt_d = 7'd0;
                end
            end
            LOCKED: begin
                if (timeout) begin
                    state_d      = UNLOCKED;
                    lock_err_d   = 1'b1;
                    relock_blk_d = 1'b1;
                end else if (!g_lock) begin
                    state_d = UNLOCKED;
                end else if (lock_cnt_q != LOCK_MAX_C) begin
                    lock_cnt_d = lock_cnt_q + 7'd1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q      <= UNLOCKED;
            lock_cnt_q   <= 7'd0;
            relock_blk_q <= 1'b0;
            favor_game_q <= 1'b0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            g_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            mem_addr_q   <= 8'h00;
            mem_wdata_q  <= 8'h00;
            mem_we_q     <= 1'b0;
            addr_err_q   <= 1'b0;
            lock_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            favor_game_q <= favor_game_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag1_q;
            g_gnt_q      <= g_gnt_d;
            d_gnt_q      <= d_gnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            addr_err_q   <= addr_err_d;
            lock_err_q   <= lock_err_d;
        end
    end

    assign g_gnt     = g_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign addr_err  = addr_err_q;
    assign lock_err  = lock_err_q;
    assign g_rvalid  = tag2_q.vld && (tag2_q.owner == OWN_GAME);
    assign d_rvalid  = tag2_q.vld && (tag2_q.owner == OWN_DISP);
    // Read data is only meaningful with a valid pulse; hold it at zero otherwise.
    assign rdata     = (g_rvalid || d_rvalid) ? mem_rdata : 8'h00;

endmodule
